// File: rtl/mux_nx1_rr.sv
// N-channel, W-bit registered multiplexer with valid/ready on every port.
// Selection is either fixed (SEL) or round-robin, chosen at runtime by MODE.
module mux_nx1_rr #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [N*W-1:0] IN,
  input  logic [N-1:0]   IN_VALID,
  output logic [N-1:0]   IN_READY,
  input  logic           MODE,
  input  logic [SW-1:0]  SEL,
  output logic [W-1:0]   Y,
  output logic           Y_VALID,
  input  logic           Y_READY,
  output logic [SW-1:0]  Y_CH
);

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  mode_e         mode;
  logic          ld;
  logic          fix_hit;
  logic          rr_hit;
  logic          gnt_vld;
  logic [SW-1:0] rr_gnt;
  logic [SW-1:0] gnt;
  logic [W-1:0]  gnt_data;

  logic [W-1:0]  y_q,       y_d;
  logic [SW-1:0] y_ch_q,    y_ch_d;
  logic          y_valid_q, y_valid_d;
  logic [SW-1:0] ptr_q,     ptr_d;

  assign mode = mode_e'(MODE);
  assign ld   = !y_valid_q || Y_READY;

  // Comparing SEL against every legal index makes SEL >= N fall out as "no grant".
  always_comb begin
    fix_hit = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (SEL == SW'(k) && IN_VALID[k]) fix_hit = 1'b1;
    end
  end

  always_comb begin
    int unsigned idx;
    idx    = '0;
    rr_hit = 1'b0;
    rr_gnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!rr_hit && IN_VALID[idx[SW-1:0]]) begin
        rr_hit = 1'b1;
        rr_gnt = idx[SW-1:0];
      end
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    unique case (mode)
      MODE_FIXED: begin
        gnt_vld = fix_hit;
        gnt     = SEL;
      end
      MODE_RR: begin
        gnt_vld = rr_hit;
        gnt     = rr_gnt;
      end
    endcase
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (gnt == SW'(k)) gnt_data = IN[k*W +: W];
    end
  end

  always_comb begin
    IN_READY = '0;
    for (int unsigned k = 0; k < N; k++) begin
      IN_READY[k] = RST_N && ld && gnt_vld && (gnt == SW'(k));
    end
  end

  always_comb begin
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = y_valid_q;
    ptr_d     = ptr_q;
    if (ld) begin
      if (gnt_vld) begin
        y_d       = gnt_data;
        y_ch_d    = gnt;
        y_valid_d = 1'b1;
        if (mode == MODE_RR) begin
          ptr_d = (gnt == SW'(N - 1)) ? '0 : gnt + 1'b1;
        end
      end else begin
        y_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign Y       = y_q;
  assign Y_CH    = y_ch_q;
  assign Y_VALID = y_valid_q;

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It generalises the team's 4x1 combinational mux: any channel count and data width, a registered output stage with backpressure, and a runtime choice between externally selected (fixed) and round-robin channel selection. It sits between multiple producers and one shared downstream consumer, such as a bus or serializer.

## Interface
- N, default 4: number of input channels, 2..16.
- W, default 8: data width per channel, 1..64.
- SW, default $clog2(N): select/channel-index width. This is a derived localparam; do not override.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset; one clock; reset is asynchronous and active-low.
- IN  input  N*W  flattened channel data; channel k occupies IN[k*W +: W].
- IN_VALID  input  N  per-channel data valid.
- IN_READY  output  N  per-channel accept; at most one bit is high.
- MODE  input  1  0 = fixed (SEL picks the channel), 1 = round-robin.
- SEL  input  SW  channel select in fixed mode; ignored in round-robin mode.
- Y  output  W  registered output data.
- Y_VALID  output  1  output register holds data.
- Y_READY  input  1  downstream accept.
- Y_CH  output  SW  index of the channel that supplied the current Y.

## Operation
- Transfer on channel k happens in a cycle where IN_VALID[k] & IN_READY[k] is high. Output transfer happens in a cycle where Y_VALID & Y_READY is high.
- Load enable: LD = !Y_VALID | Y_READY. The register accepts a new word when it is empty or is being drained in the same cycle.
- Grant selection is combinational from the current-cycle inputs.
  - Fixed mode: grant channel SEL when SEL < N and IN_VALID[SEL] = 1. Otherwise there is no grant. SEL >= N never grants.
  - Round-robin mode: search channels PTR, PTR+1, …, N-1, 0, …, PTR-1. Grant the first one with IN_VALID set. No valid inputs means no grant.
- IN_READY[g] = LD & (a grant exists) & (g == grant). All other bits are 0.
- On a transfer from channel g:
  - Y <= channel g data.
  - Y_CH <= g.
  - Y_VALID <= 1.
- When LD = 1 and there is no grant: Y_VALID <= 0. Y and Y_CH hold their previous values.
- When LD = 0 (Y_VALID & !Y_READY): Y, Y_CH and Y_VALID hold stable. All IN_READY bits are 0.
- PTR (SW bits, internal):
  - It updates only on a round-robin-mode transfer: PTR <= (g+1) mod N. For g = N-1 it wraps to 0. This applies to non-power-of-two N as well.
  - In fixed mode PTR holds its value.
  - A switch from fixed to round-robin mode resumes from the held PTR.
- MODE and SEL may change on any cycle. Their effect is immediate on the combinational grant. A word already in the output register is unaffected.
- A channel that drops IN_VALID without a transfer is legal. The arbiter simply does not grant it.

## Timing
- Reset values (async assert, synchronous deassert by the system):
  - Y = 0, Y_CH = 0, Y_VALID = 0, PTR = 0.
  - IN_READY = 0 while RST_N is low.
- Latency: 1 cycle. Data accepted at edge t appears on Y with Y_VALID high after edge t.
- Throughput: 1 word per cycle while Y_READY stays high.
- Y_READY affects IN_READY combinationally in the same cycle. There is no skid buffer and no combinational path from IN to Y.
- Reset mid-operation: any word held in the output register is discarded. The next granted word after reset release comes from channel 0 first in round-robin mode.
- Simultaneous drain and fill (Y_VALID, Y_READY and a grant all in one cycle): the old word leaves and the new word loads on the same edge. Y_VALID stays 1 with no bubble.

## Test plan
- Reset, then fixed mode:
  - Stimulus: SEL = 2, IN_VALID = 4'b0100, channel 2 data = 8'hA5, Y_READY = 1.
  - Response: IN_READY = 4'b0100. The next cycle shows Y = 8'hA5, Y_CH = 2, Y_VALID = 1.
- Round-robin fairness:
  - Stimulus: all four channels valid continuously (data 8'h10/11/12/13), Y_READY = 1.
  - Response: Y_CH sequence 0, 1, 2, 3, 0, … with one word per cycle.
- Backpressure:
  - Stimulus: Y_VALID = 1 with Y_READY = 0 held for 3 cycles.
  - Response: Y and Y_CH are stable, IN_READY = 0 throughout. When Y_READY rises, the next word loads with no gap.
- Sparse round-robin with wrap:
  - Stimulus: N = 5, PTR = 4, IN_VALID = 5'b00010.
  - Response: grant channel 1, after which PTR = 2. Next, with IN_VALID = 5'b10000: grant channel 4, after which PTR wraps to 0.
- Fixed-mode edge cases:
  - Stimulus: SEL = 5 with N = 5, all inputs valid.
  - Response: IN_READY = 0 and Y_VALID falls to 0 once drained.
  - Stimulus: switch MODE from 0 to 1 while PTR = 3.
  - Response: the search starts at channel 3.
- Reset mid-stream:
  - Stimulus: assert RST_N low while Y_VALID = 1.
  - Response: Y_VALID = 0, Y = 0 and Y_CH = 0 immediately (asynchronously). After release, the first round-robin grant goes to the lowest valid channel starting from 0.
